// File: rtl/fp_scaleb_pipe_if.sv
// Operand/result handshake bundle for fp_scaleb_pipe; the pipeline is the slave,
// the producer/consumer side is the master.
interface fp_scaleb_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int B_W    = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_W+FRAC_W:0]   a;
  logic [B_W-1:0]          b;
  logic [EXP_W+FRAC_W:0]   o;
  logic                    out_valid;
  logic                    out_ready;
  logic                    ovf;
  logic                    unf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, o, out_valid, ovf, unf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, o, out_valid, ovf, unf
  );
endinterface

// File: rtl/fp_scaleb_pipe.sv
// 3-stage a*2^b pipeline (decode/normalise, exponent add/classify, pack).
// Define FP_SCALEB_SUBNORM_EN for round-to-nearest-even subnormal results; default flushes to zero.
module fp_scaleb_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int B_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  fp_scaleb_pipe_if.slave bus
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int EXW = EXP_W + 2;
  localparam int EW2 = EXP_W + B_W + 2;
  localparam int LZW = $clog2(FRAC_W + 1);
  localparam logic signed [EW2-1:0] E_INF = EW2'((2**EXP_W) - 1);
`ifdef FP_SCALEB_SUBNORM_EN
  localparam int SHW = $clog2(FRAC_W + 2);
  localparam int WW  = 2*FRAC_W + 3;
  localparam logic signed [EW2-1:0] E_BIG = EW2'(-(FRAC_W + 1));
`endif

  logic advance;
  assign advance      = ce & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = advance;

  // ---------------- S1: decode / normalise ----------------
  logic                  sa;
  logic [EXP_W-1:0]      ea;
  logic [FRAC_W-1:0]     fa;
  logic [LZW-1:0]        lz;
  logic                  spec_d;
  logic [W-1:0]          spec_o_d;
  logic signed [EXW-1:0] exp1_d;
  logic [FRAC_W-1:0]     frac1_d;

  assign {sa, ea, fa} = bus.a;

  always_comb begin
    int unsigned msb;
    msb = 0;
    for (int unsigned i = 0; i < FRAC_W; i++)
      if (fa[i]) msb = i;
    lz       = LZW'(FRAC_W - msb);
    spec_d   = (ea == '1) | ((ea == '0) & (fa == '0));
    spec_o_d = bus.a;
    if ((ea == '1) && (fa != '0)) spec_o_d[FRAC_W-1] = 1'b1;
    // Subnormals: shifting by lz pushes the leading one out into the hidden position.
    if (ea == '0) begin
      exp1_d  = EXW'(1) - EXW'(lz);
      frac1_d = fa << lz;
    end else begin
      exp1_d  = EXW'(ea);
      frac1_d = fa;
    end
  end

  logic                  v1, spec1, sign1;
  logic [W-1:0]          spec_o1;
  logic signed [EXW-1:0] exp1;
  logic [FRAC_W-1:0]     frac1;
  logic [B_W-1:0]        b1;

  // ---------------- S2: exponent add / classify ----------------
  logic signed [EW2-1:0] e2;
  assign e2 = $signed({{B_W{exp1[EXW-1]}}, exp1})
            + $signed({{(EXP_W+2){b1[B_W-1]}}, b1});

  logic              v2, spec2, sign2, ovf2, tiny2;
  logic [W-1:0]      spec_o2;
  logic [EXP_W-1:0]  exp2;
  logic [FRAC_W-1:0] frac2;
`ifdef FP_SCALEB_SUBNORM_EN
  logic              big2;
  logic [SHW-1:0]    sh2;
`endif

  // ---------------- S3: shift / round / pack ----------------
  logic [W-1:0] o_nx;
  logic         ovf_nx, unf_nx;
`ifdef FP_SCALEB_SUBNORM_EN
  logic [WW-1:0]     wide;
  logic [FRAC_W:0]   q, r;
  logic              guard, sticky;
`endif

  always_comb begin
    o_nx   = '0;
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
`ifdef FP_SCALEB_SUBNORM_EN
    wide   = '0;
    q      = '0;
    r      = '0;
    guard  = 1'b0;
    sticky = 1'b0;
`endif
    if (spec2) begin
      o_nx = spec_o2;
    end else if (ovf2) begin
      o_nx   = {sign2, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_nx = 1'b1;
    end else if (!tiny2) begin
      o_nx = {sign2, exp2, frac2};
    end else begin
`ifdef FP_SCALEB_SUBNORM_EN
      if (big2) begin
        o_nx   = {sign2, {(W-1){1'b0}}};
        unf_nx = 1'b1;
      end else begin
        wide   = {1'b1, frac2, {(FRAC_W+2){1'b0}}} >> sh2;
        q      = wide[WW-1 -: FRAC_W+1];
        guard  = wide[FRAC_W+1];
        sticky = |wide[FRAC_W:0];
        r      = q + {{FRAC_W{1'b0}}, guard & (sticky | q[0])};
        // A rounding carry lands in r[FRAC_W], which is exactly exp field = 1.
        o_nx   = {sign2, {(EXP_W-1){1'b0}}, r};
        unf_nx = guard | sticky;
      end
`else
      o_nx   = {sign2, {(W-1){1'b0}}};
      unf_nx = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.o         <= '0;
      bus.ovf       <= 1'b0;
      bus.unf       <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        spec1   <= spec_d;
        spec_o1 <= spec_o_d;
        sign1   <= sa;
        exp1    <= exp1_d;
        frac1   <= frac1_d;
        b1      <= bus.b;
      end
      v2 <= v1;
      if (v1) begin
        spec2   <= spec1;
        spec_o2 <= spec_o1;
        sign2   <= sign1;
        frac2   <= frac1;
        exp2    <= e2[EXP_W-1:0];
        ovf2    <= (e2 >= E_INF);
        tiny2   <= e2[EW2-1] | (e2 == '0);
`ifdef FP_SCALEB_SUBNORM_EN
        big2    <= (e2 <= E_BIG);
        sh2     <= SHW'(1) - e2[SHW-1:0];
`endif
      end
      bus.out_valid <= v2;
      if (v2) begin
        bus.o   <= o_nx;
        bus.ovf <= ovf_nx;
        bus.unf <= unf_nx;
      end
    end
  end
endmodule

// File: doc/fp_scaleb_pipe.md
FP_SCALEB_PIPE -- requirements
Module: fp_scaleb_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter FRAC_W, default 23: stored fraction width, hidden bit excluded.
REQ-003 Parameter B_W, default 16: width of the signed scale operand.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port ce, input, 1: clock enable; when low, all state holds.
REQ-007 Port in_valid, input, 1: a and b are valid.
REQ-008 Port in_ready, output, 1: pipeline accepts a new operand pair this cycle.
REQ-009 Port a, input, 1+EXP_W+FRAC_W: IEEE-style operand {sign, exp, frac}.
REQ-010 Port b, input, B_W: two's-complement scale amount n.
REQ-011 Port o, output, 1+EXP_W+FRAC_W: result a*2^n.
REQ-012 Port out_valid, output, 1: o, ovf and unf are valid.
REQ-013 Port out_ready, input, 1: consumer takes the result.
REQ-014 Port ovf, output, 1: result overflowed to infinity.
REQ-015 Port unf, output, 1: result is tiny and inexact.

Function
REQ-016 Pipeline SHALL be 3 stages: S1 decode/normalise, S2 exponent add/classify, S3 shift/round/pack; latency 3 cycles from accept to out_valid.
REQ-017 advance = ce & (~out_valid | out_ready); in_ready = advance; an accept occurs on in_valid & in_ready.
REQ-018 When advance is low, every stage SHALL hold; o, ovf and unf SHALL stay stable while out_valid & ~out_ready.
REQ-019 Bubbles SHALL propagate as invalid stages, with no loss or duplication of results; sustained throughput is 1 result per cycle.
REQ-020 S1: a subnormal a SHALL be normalised by a leading-zero count lz: effective exponent = 1-lz, and the fraction is left-shifted by lz so the hidden bit is 1.
REQ-021 S2: e = eff_exp + sign_extend(b), computed at EXP_W+B_W+2 bits signed; no wrap-around is permitted.
REQ-022 a NaN SHALL produce o = a with the fraction MSB forced to 1 (quieted), and ovf = unf = 0.
REQ-023 a = ±0 or ±inf SHALL produce o = a, and ovf = unf = 0, for any b.
REQ-024 e >= 2^EXP_W-1 SHALL produce o = {sa, all-ones exp, 0}, and ovf = 1.
REQ-025 1 <= e < 2^EXP_W-1 SHALL produce o = {sa, e[EXP_W-1:0], frac}; the result is exact, and ovf = unf = 0.
REQ-026 e <= 0 SHALL be handled per REQ-033/REQ-034.
REQ-027 The sign of o SHALL always equal the sign of a, except where REQ-022 applies.

Reset
REQ-028 When rst is high at a clock edge, all stage-valid bits SHALL clear regardless of ce; in-flight operations are discarded.
REQ-029 Reset values: out_valid = 0, o = 0, ovf = 0, unf = 0.
REQ-030 in_ready SHALL follow REQ-017 during reset, so it is high whenever ce is high; the first accept is possible in the cycle after rst is deasserted.

Configuration
REQ-031 Macro FP_SCALEB_SUBNORM_EN selects how results with e <= 0 are produced.
REQ-032 Subnormal inputs are always normalised (REQ-020), whether or not the macro is defined.
REQ-033 With FP_SCALEB_SUBNORM_EN defined:
- the significand SHALL be right-shifted by 1-e, with guard and sticky bits, and rounded to nearest-even;
- a shift of FRAC_W+2 or more yields ±0 with sticky set;
- a rounding carry into exp = 1 SHALL yield the minimum normal;
- unf = 1 if and only if the result is inexact.
REQ-034 With FP_SCALEB_SUBNORM_EN undefined: e <= 0 SHALL flush to ±0 with unf = 1, and no rounding logic SHALL be present.

Verification
REQ-035 Default parameters. Directed scenarios:
- Scaling: a=0x3F800000, b=3 -> o=0x41000000, ovf=0, unf=0, out_valid exactly 3 cycles after accept.
- Overflow and NaN: a=0x3F800000, b=200 -> o=0x7F800000, ovf=1. Then a=0x7FA00000, b=5 -> o=0x7FE00000, ovf=0, unf=0.
- Subnormal with FP_SCALEB_SUBNORM_EN defined: a=0x3F800000, b=-127 -> o=0x00400000, unf=0. Then a=0x3FC00000, b=-149 -> o=0x00000002, unf=1. Then a=0x00000001, b=149 -> o=0x3F800000.
- Subnormal with FP_SCALEB_SUBNORM_EN undefined: a=0x3F800000, b=-127 -> o=0x00000000, unf=1. Then a=0xBF800000, b=-32768 -> o=0x80000000, unf=1.
- Backpressure: issue 6 back-to-back operations while holding out_ready low for 4 cycles -> in_ready drops while out_valid & ~out_ready, o stays stable, and all 6 results arrive in order with none lost or duplicated. Toggle ce low for 2 cycles -> all state frozen.
- Reset mid-operation: assert rst with 3 operations in flight -> out_valid=0 and o=0 on the next cycle, and no stale result appears after rst is released.
